radar_signal_generator: RTL and testbench

Synthesizable source of the radar timing signals ARP (azimuth reference, one per rotation), ACP (azimuth change pulses, N per rotation) and TRIG (transmit trigger, fixed period). It drives the same ARP/ACP/TRIG inputs that the radar statistics block measures. All timing runs on the 1 µs clock, so periods are programmed directly in microseconds. Configuration is latched on start, and invalid configurations are rejected with an error flag.

---
 rtl/radar_signal_generator_if.sv | 35 +++
 rtl/radar_signal_generator.sv | 167 ++++++++++++++++
 tb/tb_radar_signal_generator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/radar_signal_generator_if.sv
// Configuration and pulse-output bundle of the radar timing generator.
//   en       : run request (level)
//   arp_us   : rotation period P in microseconds
//   acp_cnt  : azimuth change pulses per rotation N
//   trig_us  : trigger period T in microseconds
//   arp/acp/trig : one-cycle timing pulses
//   running/cfg_err : state indicators
//   rot_cnt  : completed rotations since the last run entry
`timescale 1ns/1ps
interface radar_signal_generator_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  en;
   logic [DATA_WIDTH-1:0] arp_us;
   logic [DATA_WIDTH-1:0] acp_cnt;
   logic [DATA_WIDTH-1:0] trig_us;
   logic                  arp;
   logic                  acp;
   logic                  trig;
   logic                  running;
   logic                  cfg_err;
   logic [DATA_WIDTH-1:0] rot_cnt;

   // Controller side: programs the generator and observes its pulses
   modport master (
      output en, arp_us, acp_cnt, trig_us,
      input  arp, acp, trig, running, cfg_err, rot_cnt
   );

   // Generator side
   modport slave (
      input  en, arp_us, acp_cnt, trig_us,
      output arp, acp, trig, running, cfg_err, rot_cnt
   );
endinterface

// File: rtl/radar_signal_generator.sv
// Radar timing source: ARP once per rotation, N ACPs per rotation and a
// free-running TRIG, all timed on the 1 MHz clock.
//   us_clk : 1 MHz clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : configuration inputs and registered pulse/status outputs
`timescale 1ns/1ps
module radar_signal_generator #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                     us_clk,
   input  logic                     rst_n,
   radar_signal_generator_if.slave  bus
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned AW = DATA_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  p_q, p_d;
   logic [DW-1:0]  n_q, n_d;
   logic [DW-1:0]  t_q, t_d;
   logic [DW-1:0]  pos_q, pos_d;
   logic [DW-1:0]  tpos_q, tpos_d;
   logic [AW-1:0]  acc_q, acc_d;
   logic [DW-1:0]  rot_q, rot_d;
   logic           arp_q, arp_d;
   logic           acp_q, acp_d;
   logic           trig_q, trig_d;
   logic           run_q, run_d;
   logic           err_q, err_d;

   logic           cfg_valid;
   logic           pos_wrap;
   logic           tpos_wrap;
   logic [DW-1:0]  pos_nxt;
   logic [DW-1:0]  tpos_nxt;
   logic [AW-1:0]  acc_sum;
   logic [AW-1:0]  acc_nxt;
   logic           acp_nxt;

   // Configuration check on the live inputs; 2N<=P done one bit wider
   assign cfg_valid = (bus.arp_us >= DW'(2))
                   && (bus.acp_cnt != '0)
                   && ({bus.acp_cnt, 1'b0} <= {1'b0, bus.arp_us})
                   && (bus.trig_us >= DW'(2));

   // Rotation position and trigger phase counters
   assign pos_wrap  = (pos_q == p_q - DW'(1));
   assign pos_nxt   = pos_wrap ? '0 : pos_q + DW'(1);
   assign tpos_wrap = (tpos_q == t_q - DW'(1));
   assign tpos_nxt  = tpos_wrap ? '0 : tpos_q + DW'(1);

   // acc holds (k*N) mod P for the current cycle; ACP of the next cycle is
   // decided one step ahead so the pulse comes straight from a flop
   assign acc_sum = acc_q + {1'b0, n_q};
   assign acc_nxt = (acc_sum >= {1'b0, p_q}) ? acc_sum - {1'b0, p_q} : acc_sum;
   assign acp_nxt = ((acc_nxt + {1'b0, n_q}) >= {1'b0, p_q});

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      n_d     = n_q;
      t_d     = t_q;
      pos_d   = pos_q;
      tpos_d  = tpos_q;
      acc_d   = acc_q;
      rot_d   = rot_q;
      arp_d   = 1'b0;
      acp_d   = 1'b0;
      trig_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.en) begin
               if (cfg_valid) begin
                  state_d = ST_RUN;
                  p_d     = bus.arp_us;
                  n_d     = bus.acp_cnt;
                  t_d     = bus.trig_us;
                  pos_d   = '0;
                  tpos_d  = '0;
                  acc_d   = '0;
                  rot_d   = '0;
                  arp_d   = 1'b1;
                  trig_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_RUN: begin
            if (!bus.en) begin
               state_d = ST_IDLE;
            end else begin
               pos_d  = pos_nxt;
               tpos_d = tpos_nxt;
               acc_d  = acc_nxt;
               arp_d  = pos_wrap;
               trig_d = tpos_wrap;
               acp_d  = acp_nxt;
               if (pos_wrap) begin
                  rot_d = rot_q + DW'(1);
               end
            end
         end
         ST_ERR: begin
            if (!bus.en) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      run_d = (state_d == ST_RUN);
      err_d = (state_d == ST_ERR);
   end

   // State and output registers
   always_ff @(posedge us_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         p_q     <= '0;
         n_q     <= '0;
         t_q     <= '0;
         pos_q   <= '0;
         tpos_q  <= '0;
         acc_q   <= '0;
         rot_q   <= '0;
         arp_q   <= 1'b0;
         acp_q   <= 1'b0;
         trig_q  <= 1'b0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         n_q     <= n_d;
         t_q     <= t_d;
         pos_q   <= pos_d;
         tpos_q  <= tpos_d;
         acc_q   <= acc_d;
         rot_q   <= rot_d;
         arp_q   <= arp_d;
         acp_q   <= acp_d;
         trig_q  <= trig_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end

   assign bus.arp     = arp_q;
   assign bus.acp     = acp_q;
   assign bus.trig    = trig_q;
   assign bus.running = run_q;
   assign bus.cfg_err = err_q;
   assign bus.rot_cnt = rot_q;

endmodule

// File: tb/tb_radar_signal_generator.sv
// Self-checking bench for radar_signal_generator: directed scenarios plus
// randomized configurations checked against closed-form timing formulas.
`timescale 1ns/1ps
module tb_radar_signal_generator;

   logic us_clk;
   logic rst_n;
   int   checks;
   int   errors;

   radar_signal_generator_if #(.DATA_WIDTH(32)) bus ();

   radar_signal_generator #(.DATA_WIDTH(32)) dut (
      .us_clk (us_clk),
      .rst_n  (rst_n),
      .bus    (bus.slave)
   );

   initial us_clk = 1'b0;
   always #5 us_clk = ~us_clk;

   task automatic step();
      @(posedge us_clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: every RUN output as a direct function of k
   task automatic check_cycle(input longint p, input longint n, input longint t,
                              input longint k);
      longint acp_e;
      acp_e = (((k + 1) * n) / p > (k * n) / p) ? 1 : 0;
      chk($sformatf("arp k=%0d", k),     longint'(bus.arp),     (k % p == 0) ? 1 : 0);
      chk($sformatf("acp k=%0d", k),     longint'(bus.acp),     acp_e);
      chk($sformatf("trig k=%0d", k),    longint'(bus.trig),    (k % t == 0) ? 1 : 0);
      chk($sformatf("running k=%0d", k), longint'(bus.running), 1);
      chk($sformatf("cfg_err k=%0d", k), longint'(bus.cfg_err), 0);
      chk($sformatf("rot_cnt k=%0d", k), longint'(bus.rot_cnt), (k / p) & 64'hFFFF_FFFF);
   endtask

   task automatic check_quiet(input string tag, input longint rot, input longint err);
      chk({tag, " arp"},     longint'(bus.arp),     0);
      chk({tag, " acp"},     longint'(bus.acp),     0);
      chk({tag, " trig"},    longint'(bus.trig),    0);
      chk({tag, " running"}, longint'(bus.running), 0);
      chk({tag, " cfg_err"}, longint'(bus.cfg_err), err);
      chk({tag, " rot_cnt"}, longint'(bus.rot_cnt), rot);
   endtask

   // Checks cycles k0..k0+ncyc-1, leaving time positioned in the last one
   task automatic run_cycles(input longint p, input longint n, input longint t,
                             input longint k0, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         check_cycle(p, n, t, k0 + longint'(i));
         if (i != ncyc - 1) step();
      end
   endtask

   task automatic set_cfg(input int unsigned p, input int unsigned n, input int unsigned t);
      bus.arp_us  = p;
      bus.acp_cnt = n;
      bus.trig_us = t;
   endtask

   initial begin
      int unsigned bad_p [3];
      int unsigned bad_n [3];
      int unsigned bad_t [3];
      int arp_edges, acp_edges, trig_edges, adjacent;
      logic prev_arp, prev_acp, prev_trig;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.en = 1'b0;
      set_cfg(0, 0, 0);
      #3;
      check_quiet("reset", 0, 0);
      @(negedge us_clk);
      rst_n = 1'b1;
      step();
      check_quiet("idle", 0, 0);

      // Basic pattern P=10 N=2 T=3
      set_cfg(10, 2, 3);
      bus.en = 1'b1;
      step();
      run_cycles(10, 2, 3, 0, 25);
      bus.en = 1'b0;
      step();
      check_quiet("stop1", 2, 0);

      // Long run P=2048 N=4 T=50 with edge counting
      set_cfg(2048, 4, 50);
      bus.en = 1'b1;
      step();
      arp_edges = 0; acp_edges = 0; trig_edges = 0; adjacent = 0;
      prev_arp = 1'b0; prev_acp = 1'b0; prev_trig = 1'b0;
      for (int k = 0; k < 10 * 2048; k++) begin
         check_cycle(2048, 4, 50, longint'(k));
         if (bus.arp && !prev_arp) arp_edges++;
         if (bus.acp && !prev_acp) acp_edges++;
         if (bus.trig && !prev_trig) trig_edges++;
         if (bus.acp && prev_acp) adjacent++;
         prev_arp = bus.arp; prev_acp = bus.acp; prev_trig = bus.trig;
         if (k != 10 * 2048 - 1) step();
      end
      chk("long arp edges", longint'(arp_edges), 10);
      chk("long acp edges", longint'(acp_edges), 40);
      chk("long trig edges", longint'(trig_edges), 410);
      chk("long adjacent acp", longint'(adjacent), 0);
      chk("long rot_cnt", longint'(bus.rot_cnt), 9);
      bus.en = 1'b0;
      step();
      check_quiet("stop2", 9, 0);

      // Invalid configurations: held in ERR, released by dropping EN
      bad_p = '{10, 1, 10};
      bad_n = '{6, 1, 2};
      bad_t = '{3, 5, 1};
      for (int i = 0; i < 3; i++) begin
         set_cfg(bad_p[i], bad_n[i], bad_t[i]);
         bus.en = 1'b1;
         step();
         check_quiet($sformatf("err%0d entry", i), 9, 1);
         step();
         step();
         check_quiet($sformatf("err%0d hold", i), 9, 1);
         bus.en = 1'b0;
         step();
         check_quiet($sformatf("err%0d exit", i), 9, 0);
      end

      // EN dropped at k=13, then restart
      set_cfg(10, 2, 3);
      bus.en = 1'b1;
      step();
      run_cycles(10, 2, 3, 0, 14);
      bus.en = 1'b0;
      step();
      check_quiet("drop13", 1, 0);
      step();
      check_quiet("drop13 hold", 1, 0);
      bus.en = 1'b1;
      step();
      run_cycles(10, 2, 3, 0, 3);

      // Config changes during RUN are ignored
      bus.en = 1'b0;
      step();
      bus.en = 1'b1;
      step();
      run_cycles(10, 2, 3, 0, 6);
      set_cfg(20, 7, 9);
      step();
      run_cycles(10, 2, 3, 6, 20);
      bus.en = 1'b0;
      step();
      check_quiet("cfgchg stop", 2, 0);

      // Asynchronous reset while ACP is high at k=7 (P=8 N=4 gives ACP on odd k)
      set_cfg(8, 4, 3);
      bus.en = 1'b1;
      step();
      run_cycles(8, 4, 3, 0, 8);
      chk("acp high before reset", longint'(bus.acp), 1);
      #1;
      rst_n  = 1'b0;
      bus.en = 1'b0;
      #1;
      check_quiet("async reset", 0, 0);
      @(negedge us_clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_quiet("post reset", 0, 0);
      end
      bus.en = 1'b1;
      step();
      run_cycles(8, 4, 3, 0, 5);
      bus.en = 1'b0;
      step();

      // Randomized valid configurations
      for (int r = 0; r < 6; r++) begin
         int unsigned p, n, t;
         int len;
         p   = $urandom_range(64, 2);
         n   = $urandom_range(p / 2, 1);
         t   = $urandom_range(40, 2);
         len = int'($urandom_range(150, 20));
         set_cfg(p, n, t);
         bus.en = 1'b1;
         step();
         run_cycles(longint'(p), longint'(n), longint'(t), 0, len);
         bus.en = 1'b0;
         step();
         check_quiet($sformatf("rand%0d stop", r), longint'((len - 1) / int'(p)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
